alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational alu between two clients.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties).
module alu_arbiter (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iREQ0,
    input  logic       iREQ1,
    input  logic [3:0] iA0,
    input  logic [3:0] iA1,
    input  logic [3:0] iB0,
    input  logic [3:0] iB1,
    input  logic [3:0] iINST0,
    input  logic [3:0] iINST1,
    output logic       oGNT0,
    output logic       oGNT1,
    output logic       oVLD0,
    output logic       oVLD1,
    output logic [7:0] oRES,
    output logic [3:0] oALU_A,
    output logic [3:0] oALU_B,
    output logic [3:0] oALU_INST,
    input  logic [7:0] iALU_RESULT,
    output logic       oBUSY,
    output logic [7:0] oCNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   win1;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic last_gnt;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            last_gnt <= 1'b1;
        end else if (state == IDLE && state_nxt == ISSUE) begin
            last_gnt <= win1;
        end
    end
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win1      = 1'b0;
        unique case (state)
            IDLE: begin
                if (iREQ0 || iREQ1) begin
                    state_nxt = ISSUE;
`ifdef ALU_ARB_FIXED_PRIO_EN
                    win1 = ~iREQ0;
`else
                    // on a tie, the client not granted last time wins
                    win1 = ~iREQ0 | (iREQ1 & ~last_gnt);
`endif
                end
            end
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oGNT0     <= 1'b0;
            oGNT1     <= 1'b0;
            oVLD0     <= 1'b0;
            oVLD1     <= 1'b0;
            oRES      <= 8'h00;
            oALU_A    <= 4'h0;
            oALU_B    <= 4'h0;
            oALU_INST <= 4'h0;
            oBUSY     <= 1'b0;
            oCNT      <= 8'h00;
        end else begin
            oGNT0 <= 1'b0;
            oGNT1 <= 1'b0;
            oVLD0 <= 1'b0;
            oVLD1 <= 1'b0;
            oBUSY <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (state_nxt == ISSUE) begin
                        oALU_A    <= win1 ? iA1 : iA0;
                        oALU_B    <= win1 ? iB1 : iB0;
                        oALU_INST <= win1 ? iINST1 : iINST0;
                        oGNT0     <= ~win1;
                        oGNT1     <= win1;
                    end
                end
                ISSUE: begin
                    // grant flags still identify the winner here
                    oRES  <= iALU_RESULT;
                    oVLD0 <= oGNT0;
                    oVLD1 <= oGNT1;
                    oCNT  <= oCNT + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
